// File: rtl/player_pkg.sv
// Shared types and constants for the player motion controller.
package player_pkg;

  // Controller phases: waiting for the game, moving, frozen after a hit, one-cycle respawn.
  typedef enum logic [1:0] {IDLE, ACTIVE, HIT, RESPAWN} state_t;

  // Per-frame horizontal intent: -1 left, 0 none, +1 right.
  typedef logic signed [1:0] dir_t;

  localparam dir_t DIR_LEFT  = -2'sd1;
  localparam dir_t DIR_NONE  = 2'sd0;
  localparam dir_t DIR_RIGHT = 2'sd1;

  localparam int FRAC_BITS_DEFAULT = 6;
  localparam int FIXED_ONE         = 1 << FRAC_BITS_DEFAULT;

  // Opposing keys cancel; a single key gives its direction.
  function automatic dir_t arrows_to_dir(input logic left, input logic right);
    if (right && !left) return DIR_RIGHT;
    if (left && !right) return DIR_LEFT;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/axis_integrator.sv
// One motion axis: velocity register (direct or ramped), fixed-point position
// accumulator and edge clamp. Position and velocity are 32-bit signed fixed point.
module axis_integrator
  import player_pkg::*;
#(
  parameter int POS_INIT   = 0,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 0,
  parameter int MAX_SPEED  = 100,
  parameter int ACCEL      = 25,
  parameter int ACCEL_MODE = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               load,
  input  logic               clr_vel,
  input  logic               step,
  input  dir_t               dir,
  output logic signed [31:0] pos
);

  localparam logic signed [31:0] P_INIT = 32'(POS_INIT);
  localparam logic signed [31:0] P_MIN  = 32'(POS_MIN);
  localparam logic signed [31:0] P_MAX  = 32'(POS_MAX);
  localparam logic signed [31:0] V_MAX  = 32'(MAX_SPEED);
  localparam logic signed [31:0] ACC    = 32'(ACCEL);

  logic signed [31:0] vel;
  logic signed [31:0] vel_upd;
  logic signed [31:0] pos_sum;
  logic signed [31:0] pos_nxt;
  logic signed [31:0] vel_nxt;

  // Frame update: new velocity first, then position, then clamp (which also stops the player).
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    vel_upd = vel;
    if (ACCEL_MODE == 0) begin
      unique case (dir)
        DIR_RIGHT: vel_upd = V_MAX;
        DIR_LEFT:  vel_upd = -V_MAX;
        default:   vel_upd = '0;
      endcase
    end else if (dir == DIR_RIGHT) begin
      vel_upd = (vel + ACC > V_MAX) ? V_MAX : vel + ACC;
    end else if (dir == DIR_LEFT) begin
      vel_upd = (vel - ACC < -V_MAX) ? -V_MAX : vel - ACC;
    end else if (vel > ACC) begin
      vel_upd = vel - ACC;
    end else if (vel < -ACC) begin
      vel_upd = vel + ACC;
    end else begin
      vel_upd = '0;
    end

    pos_sum = pos + vel_upd;
    pos_nxt = pos_sum;
    vel_nxt = vel_upd;
    if (pos_sum < P_MIN) begin
      pos_nxt = P_MIN;
      vel_nxt = '0;
    end else if (pos_sum > P_MAX) begin
      pos_nxt = P_MAX;
      vel_nxt = '0;
    end
  end

  // Axis state: reload beats a hit stop, which beats a frame step.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetN) begin
      pos <= P_INIT;
      vel <= '0;
    end else if (load) begin
      pos <= P_INIT;
      vel <= '0;
    end else if (clr_vel) begin
      vel <= '0;
    end else if (step) begin
      pos <= pos_nxt;
      vel <= vel_nxt;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player motion controller: key latching, IDLE/ACTIVE/HIT/RESPAWN sequencing,
// hit freeze with blinking, and the horizontal axis integrator.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int INITIAL_X    = 240,
  parameter int INITIAL_Y    = 420,
  parameter int X_MIN        = 15,
  parameter int X_MAX        = 562,
  parameter int FRAC_BITS    = FRAC_BITS_DEFAULT,
  parameter int MAX_SPEED    = 100,
  parameter int ACCEL        = 25,
  parameter int ACCEL_MODE   = 1,
  parameter int HIT_FRAMES   = 60,
  parameter int BLINK_PERIOD = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               playGame,
  input  logic               leftArrow,
  input  logic               rightArrow,
  input  logic               playerHit,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               playerVisible,
  output logic               atLeftEdge,
  output logic               atRightEdge,
  output logic               respawnPulse
);

  localparam int HC_W = $clog2(HIT_FRAMES + 1);
  localparam int BC_W = $clog2(BLINK_PERIOD + 1);
  localparam logic signed [10:0] X_MIN_PX = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_PX = 11'(X_MAX);

  state_t             state, state_nxt;
  logic               left_latch, right_latch;
  dir_t               frame_dir;
  logic               load_x, clr_vel_x, step_x;
  logic [HC_W-1:0]    hit_cnt;
  logic [BC_W-1:0]    blink_cnt;
  logic               blink_phase;
  logic signed [31:0] pos_x;

  // Arrows seen in the SOF cycle itself still count for that frame.
  assign frame_dir = arrows_to_dir(left_latch | leftArrow, right_latch | rightArrow);

  // Phase register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next phase and axis commands; playGame low overrides everything.
  always_comb begin
    state_nxt = state;
    load_x    = 1'b0;
    clr_vel_x = 1'b0;
    step_x    = 1'b0;
    unique case (state)
      IDLE: begin
        load_x    = 1'b1;
        state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (playerHit) begin
          state_nxt = HIT;
          clr_vel_x = 1'b1;
        end else if (startOfFrame) begin
          step_x = 1'b1;
        end
      end
      HIT: begin
        if (startOfFrame && hit_cnt <= HC_W'(1)) begin
          state_nxt = RESPAWN;
          load_x    = 1'b1;
        end
      end
      RESPAWN: begin
        load_x    = 1'b1;
        state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!playGame) begin
      state_nxt = IDLE;
      load_x    = 1'b1;
    end
  end

  // Sticky key latches: collect presses between frames while moving, cleared on use or hit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      left_latch  <= 1'b0;
      right_latch <= 1'b0;
    end else if (state == ACTIVE && playGame && !playerHit && !startOfFrame) begin
      left_latch  <= left_latch | leftArrow;
      right_latch <= right_latch | rightArrow;
    end else begin
      left_latch  <= 1'b0;
      right_latch <= 1'b0;
    end
  end

  // Hit freeze length and blink phase, both advanced once per frame while in HIT.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state == ACTIVE && playerHit) begin
      hit_cnt     <= HC_W'(HIT_FRAMES);
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state == HIT && startOfFrame) begin
      if (hit_cnt != '0) hit_cnt <= hit_cnt - HC_W'(1);
      if (blink_cnt == BC_W'(BLINK_PERIOD - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  axis_integrator #(
    .POS_INIT   (INITIAL_X << FRAC_BITS),
    .POS_MIN    (X_MIN << FRAC_BITS),
    .POS_MAX    (X_MAX << FRAC_BITS),
    .MAX_SPEED  (MAX_SPEED),
    .ACCEL      (ACCEL),
    .ACCEL_MODE (ACCEL_MODE)
  ) u_axis_x (
    .clk     (clk),
    .resetN  (resetN),
    .load    (load_x),
    .clr_vel (clr_vel_x),
    .step    (step_x),
    .dir     (frame_dir),
    .pos     (pos_x)
  );

  assign topLeftX      = 11'(pos_x >>> FRAC_BITS);
  assign topLeftY      = 11'(INITIAL_Y);
  assign atLeftEdge    = (topLeftX == X_MIN_PX);
  assign atRightEdge   = (topLeftX == X_MAX_PX);
  assign playerVisible = (state == HIT) ? blink_phase : 1'b1;
  assign respawnPulse  = (state == RESPAWN);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboarded bench: two controllers (ramp and direct mode) share stimulus; a
// frame-level reference model queues expected outputs that a monitor pops each cycle.
module tb_player_motion_ctrl;
  import player_pkg::*;

  localparam int INIT_X = 240, INIT_Y = 420, XMIN = 15, XMAX = 562;
  localparam int VMAX = 100, ACC = 25, HITF = 60, BP = 4, ONE = FIXED_ONE;
  localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_RESP = 3;

  logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, pg = 1'b0, la = 1'b0, ra = 1'b0, hit = 1'b0;
  logic signed [10:0] r_x, r_y, d_x, d_y;
  logic r_vis, r_le, r_re, r_resp, d_vis, d_le, d_re, d_resp;

  always #5 clk = ~clk;

  player_motion_ctrl #(.ACCEL_MODE(1)) dut_ramp (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(pg),
    .leftArrow(la), .rightArrow(ra), .playerHit(hit),
    .topLeftX(r_x), .topLeftY(r_y), .playerVisible(r_vis),
    .atLeftEdge(r_le), .atRightEdge(r_re), .respawnPulse(r_resp));

  player_motion_ctrl #(.ACCEL_MODE(0)) dut_direct (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(pg),
    .leftArrow(la), .rightArrow(ra), .playerHit(hit),
    .topLeftX(d_x), .topLeftY(d_y), .playerVisible(d_vis),
    .atLeftEdge(d_le), .atRightEdge(d_re), .respawnPulse(d_resp));

  typedef struct { int st; int x; int v; int left; int since; bit ll; bit lr; } mdl_t;
  typedef struct packed {
    logic signed [10:0] x; logic signed [10:0] y; logic vis; logic resp; logic le; logic re;
  } obs_t;

  obs_t exp_q_r[$], exp_q_d[$];
  mdl_t m_r, m_d;
  int   n_tests = 0, n_fail = 0;
  bit   rst_set = 1'b0, pg_set = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference behaviour, one clock at a time, expressed as frame rules.
  function automatic mdl_t mdl_step(input mdl_t m, input bit ramp, input bit rst, input bit pgv,
                                    input bit s, input bit l, input bit r, input bit h);
    int dir;
    if (!rst || !pgv) begin
      m.st = S_IDLE; m.x = INIT_X * ONE; m.v = 0; m.ll = 0; m.lr = 0;
      return m;
    end
    case (m.st)
      S_IDLE: m.st = S_PLAY;
      S_PLAY: begin
        if (h) begin
          m.st = S_HIT; m.v = 0; m.left = HITF; m.since = 0; m.ll = 0; m.lr = 0;
        end else if (s) begin
          dir = int'(m.lr | r) - int'(m.ll | l);
          if (!ramp) m.v = dir * VMAX;
          else if (dir != 0) begin
            m.v = m.v + dir * ACC;
            if (m.v > VMAX) m.v = VMAX;
            if (m.v < -VMAX) m.v = -VMAX;
          end else if (m.v > 0) m.v = (m.v > ACC) ? m.v - ACC : 0;
          else m.v = (m.v < -ACC) ? m.v + ACC : 0;
          m.x = m.x + m.v;
          if (m.x < XMIN * ONE) begin m.x = XMIN * ONE; m.v = 0; end
          if (m.x > XMAX * ONE) begin m.x = XMAX * ONE; m.v = 0; end
          m.ll = 0; m.lr = 0;
        end else begin
          m.ll = m.ll | l; m.lr = m.lr | r;
        end
      end
      S_HIT: begin
        if (s) begin
          m.left--; m.since++;
          if (m.left == 0) begin m.st = S_RESP; m.x = INIT_X * ONE; m.v = 0; end
        end
      end
      default: m.st = S_PLAY;
    endcase
    return m;
  endfunction

  function automatic obs_t mdl_obs(input mdl_t m);
    obs_t o;
    o.x    = 11'(m.x / ONE);
    o.y    = 11'(INIT_Y);
    o.vis  = (m.st == S_HIT) ? (((m.since / BP) % 2) == 1) : 1'b1;
    o.resp = (m.st == S_RESP);
    o.le   = (m.x / ONE == XMIN);
    o.re   = (m.x / ONE == XMAX);
    return o;
  endfunction

  // One stimulus cycle: drive at negedge, advance both models, queue expectations.
  task automatic tick(input bit s, input bit l, input bit r, input bit h);
    @(negedge clk);
    resetN = rst_set; pg = pg_set; sof = s; la = l; ra = r; hit = h;
    m_r = mdl_step(m_r, 1'b1, rst_set, pg_set, s, l, r, h);
    m_d = mdl_step(m_d, 1'b0, rst_set, pg_set, s, l, r, h);
    exp_q_r.push_back(mdl_obs(m_r));
    exp_q_d.push_back(mdl_obs(m_d));
  endtask

  task automatic frame(input bit l, input bit r);
    repeat (5) tick(1'b0, l, r, 1'b0);
    tick(1'b1, l, r, 1'b0);
  endtask

  task automatic hit_frame();
    repeat (5) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Monitor: every cycle the DUTs present a new output set; compare against the queue head.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q_r.size() > 0) begin
        e = exp_q_r.pop_front();
        check("ramp_outputs", {r_x, r_y, r_vis, r_resp, r_le, r_re}, e);
      end
      if (exp_q_d.size() > 0) begin
        e = exp_q_d.pop_front();
        check("direct_outputs", {d_x, d_y, d_vis, d_resp, d_le, d_re}, e);
      end
    end
  end

  initial begin
    int hold_x;
    bit hl, hr;
    hl = 0; hr = 0;

    // Reset
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("reset_x", r_x, 240);
    check("reset_y", r_y, 420);
    check("reset_vis", r_vis, 1);
    check("reset_resp_edges", {r_resp, r_le, r_re}, 0);

    // Game start coincident with a frame pulse: no motion
    rst_set = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    pg_set = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("start_no_motion", {r_x, d_x}, {11'sd240, 11'sd240});

    // Single-cycle press between frames
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("short_press_x", d_x, 241);
    frame(1'b0, 1'b0);
    settle();
    check("short_press_after", d_x, 241);

    // Ramp up and coast down
    repeat (6) frame(1'b0, 1'b1);
    settle();
    check("ramp_up_x", r_x, 247);
    repeat (4) frame(1'b0, 1'b0);
    settle();
    check("ramp_down_x", r_x, 249);

    // Right-edge clamp, then hold
    repeat (230) frame(1'b0, 1'b1);
    settle();
    check("right_clamp", {r_x, r_re, d_x, d_re}, {11'sd562, 1'b1, 11'sd562, 1'b1});
    repeat (10) frame(1'b0, 1'b1);
    settle();
    check("right_clamp_hold", {r_x, d_x}, {11'sd562, 11'sd562});

    // Left-edge clamp
    repeat (380) frame(1'b1, 1'b0);
    settle();
    check("left_clamp", {r_x, r_le, d_x, d_le}, {11'sd15, 1'b1, 11'sd15, 1'b1});

    // Move away from the edge, then hit mid-frame
    repeat (40) frame(1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    hold_x = m_r.x / ONE;
    settle();
    check("hit_vis_off", {r_vis, d_vis}, 0);
    repeat (4) hit_frame();
    settle();
    check("hit_vis_on", r_vis, 1);
    repeat (4) hit_frame();
    settle();
    check("hit_vis_off_again", r_vis, 0);
    check("hit_frozen_x", r_x, 11'(hold_x));
    repeat (52) hit_frame();
    settle();
    check("respawn_pulse", {r_resp, r_x, r_vis}, {1'b1, 11'sd240, 1'b1});
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("respawn_done", {r_resp, r_x, r_vis}, {1'b0, 11'sd240, 1'b1});

    // Hit coincident with frame pulse: no motion that frame
    repeat (3) frame(1'b0, 1'b1);
    hold_x = m_r.x / ONE;
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    check("hit_with_sof_x", r_x, 11'(hold_x));

    // Game stop partway through HIT
    repeat (30) hit_frame();
    pg_set = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("stop_in_hit", {r_x, r_vis, r_resp, d_x, d_vis}, {11'sd240, 1'b1, 1'b0, 11'sd240, 1'b1});
    pg_set = 1'b1;

    // Randomised play
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        hl = 1'($urandom_range(0, 1));
        hr = 1'($urandom_range(0, 1));
      end
      pg_set = ($urandom_range(0, 699) != 0);
      tick($urandom_range(0, 5) == 0, hl | ($urandom_range(0, 15) == 0), hr,
           $urandom_range(0, 299) == 0);
    end
    pg_set = 1'b1;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (exp_q_r.size() + exp_q_d.size()) > 0; i++) @(posedge clk);
    #5;
    check("scoreboard_drained", exp_q_r.size() + exp_q_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
